lsu_mem_ctrl: RTL and testbench

Load/store unit sitting directly upstream of the DRAM block. Accepts one memory request at a time from the execute stage over a valid/ready handshake. Drives the DRAM port with a word-aligned address, a replicated write data word and a byte mask, and waits a programmable number of cycles. Returns aligned, sign- or zero-extended load data (or a misalignment error) over a held valid/ready response channel.

---
 rtl/lsu_mem_ctrl.sv | 113 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit driving a fixed-latency DRAM port
module lsu_mem_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dram_en,
    output logic        dram_wen,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [3:0]  dram_wmask,
    input  logic [31:0] dram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        mis, acc, st;
    logic [3:0]  mask;
    logic [31:0] wrep, ld;
    logic [7:0]  lb;
    logic [15:0] lh;
    assign mis = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign acc = state_q == ACCESS;
    assign st  = acc && wen_q;
    assign mask = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                  size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wrep = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                  size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign lb = dram_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lh = dram_rdata[{addr_q[1], 4'b0000} +: 16];
    assign ld = size_q == 2'b00 ? {{24{lb[7] & ~uns_q}}, lb} :
                size_q == 2'b01 ? {{16{lh[15] & ~uns_q}}, lh} : dram_rdata;
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dram_en    = acc;
    assign dram_wen   = st && cnt_q == 4'd0;
    assign dram_addr  = acc ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dram_wdata = st ? wrep : 32'd0;
    assign dram_wmask = st ? mask : 4'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                wen_d   = req_wen;
                uns_d   = req_unsigned;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                rdata_d = 32'd0;
                err_d   = mis;
                cnt_d   = mis ? 4'd0 : 4'(LATENCY - 1);
                state_d = mis ? RESP : ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    rdata_d = wen_q ? 32'd0 : ld;
                    state_d = RESP;
                end
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench with a LATENCY=1 unit (a) and a LATENCY=4 unit (b)
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0] req_size;
    logic va, rra, vb, rrb;
    logic [31:0] dra, drb;
    logic ra, rva, ea, dea, dwa, rb, rvb, eb, deb, dwb;
    logic [31:0] rda, daa, dwda, rdb, dab, dwdb;
    logic [3:0] dma, dmb;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(ra), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(rva), .resp_ready(rra), .resp_rdata(rda),
        .resp_err(ea), .dram_en(dea), .dram_wen(dwa), .dram_addr(daa), .dram_wdata(dwda),
        .dram_wmask(dma), .dram_rdata(dra)
    );

    lsu_mem_ctrl #(.LATENCY(4)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(rb), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(rvb), .resp_ready(rrb), .resp_rdata(rdb),
        .resp_err(eb), .dram_en(deb), .dram_wen(dwb), .dram_addr(dab), .dram_wdata(dwdb),
        .dram_wmask(dmb), .dram_rdata(drb)
    );

    // Drives one request for a single cycle; returns on the negedge after the accepting edge.
    task automatic issue(input logic to_b, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s, input logic u);
        req_wen = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
        if (to_b) vb = 1'b1; else va = 1'b1;
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({ra, rva, ea, rda} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_bad++; $display("FAIL reset_resp: ready/valid/err/rdata=%b%b%b %h want 100 0", ra, rva, ea, rda);
        end
        n_cmp++;
        if ({dea, dwa, daa, dwda, dma} !== 70'd0) begin
            n_bad++; $display("FAIL reset_dram: en=%b wen=%b addr=%h wd=%h mask=%b want all 0", dea, dwa, daa, dwda, dma);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_store_word();
        issue(1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0);
        n_cmp++;
        if ({dea, dwa, ra, daa, dwda, dma} !== {3'b110, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111}) begin
            n_bad++; $display("FAIL st_word_access: en%b wen%b rdy%b addr=%h wd=%h mask=%b", dea, dwa, ra, daa, dwda, dma);
        end
        @(negedge clk);
        n_cmp++;
        if ({rva, ea, rda, dea, dwa} !== {2'b10, 32'd0, 2'b00}) begin
            n_bad++; $display("FAIL st_word_resp: valid%b err%b rdata=%h en%b wen%b want 1 0 0 0 0", rva, ea, rda, dea, dwa);
        end
        @(negedge clk);
        n_cmp++;
        if ({ra, rva} !== 2'b10) begin
            n_bad++; $display("FAIL st_word_idle: ready%b valid%b want 1 0", ra, rva);
        end
    endtask

    task automatic test_byte();
        issue(1'b0, 1'b1, 32'h8000_0003, 32'h1234_56A5, 2'b00, 1'b0);
        n_cmp++;
        if ({dwa, daa, dwda, dma} !== {1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 4'b1000}) begin
            n_bad++; $display("FAIL st_byte: wen%b addr=%h wd=%h mask=%b want 1 80000000 a5a5a5a5 1000", dwa, daa, dwda, dma);
        end
        @(negedge clk); @(negedge clk);
        dra = 32'hA500_0000;
        issue(1'b0, 1'b0, 32'h8000_0003, 32'hFFFF_FFFF, 2'b00, 1'b0);
        n_cmp++;
        if ({dea, dwa, dwda, dma} !== {2'b10, 32'd0, 4'd0}) begin
            n_bad++; $display("FAIL ld_byte_access: en%b wen%b wd=%h mask=%b want 1 0 0 0", dea, dwa, dwda, dma);
        end
        @(negedge clk);
        n_cmp++;
        if ({rva, ea, rda} !== {2'b10, 32'hFFFF_FFA5}) begin
            n_bad++; $display("FAIL ld_byte_signed: valid%b err%b rdata=%h want 1 0 ffffffa5", rva, ea, rda);
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h8000_0003, 32'd0, 2'b00, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (rda !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL ld_byte_unsigned: rdata=%h want 000000a5", rda);
        end
        @(negedge clk);
        dra = 32'h1122_3344;
        issue(1'b0, 1'b0, 32'h8000_0001, 32'd0, 2'b00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (rda !== 32'h0000_0033) begin
            n_bad++; $display("FAIL ld_byte_lane1: rdata=%h want 00000033", rda);
        end
        @(negedge clk);
    endtask

    task automatic test_half();
        dra = 32'h8001_1234;
        issue(1'b0, 1'b0, 32'h8000_0002, 32'd0, 2'b01, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (rda !== 32'hFFFF_8001) begin
            n_bad++; $display("FAIL ld_half_signed: rdata=%h want ffff8001", rda);
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h8000_0000, 32'd0, 2'b01, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (rda !== 32'h0000_1234) begin
            n_bad++; $display("FAIL ld_half_unsigned: rdata=%h want 00001234", rda);
        end
        @(negedge clk);
        issue(1'b0, 1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'b01, 1'b0);
        n_cmp++;
        if ({dwa, dwda, dma} !== {1'b1, 32'hBEEF_BEEF, 4'b1100}) begin
            n_bad++; $display("FAIL st_half: wen%b wd=%h mask=%b want 1 beefbeef 1100", dwa, dwda, dma);
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_errors();
        dra = 32'hFFFF_FFFF;
        issue(1'b0, 1'b0, 32'h8000_0002, 32'd0, 2'b10, 1'b0);
        n_cmp++;
        if ({rva, ea, rda, dea} !== {2'b11, 32'd0, 1'b0}) begin
            n_bad++; $display("FAIL err_word: valid%b err%b rdata=%h en%b want 1 1 0 0", rva, ea, rda, dea);
        end
        @(negedge clk);
        n_cmp++;
        if ({ra, rva} !== 2'b10) begin
            n_bad++; $display("FAIL err_word_idle: ready%b valid%b want 1 0", ra, rva);
        end
        issue(1'b0, 1'b1, 32'h8000_0000, 32'h1, 2'b11, 1'b0);
        n_cmp++;
        if ({rva, ea, rda, dea, dwa} !== {2'b11, 32'd0, 2'b00}) begin
            n_bad++; $display("FAIL err_size: valid%b err%b rdata=%h en%b wen%b want 1 1 0 0 0", rva, ea, rda, dea, dwa);
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h8000_0001, 32'd0, 2'b01, 1'b0);
        n_cmp++;
        if ({rva, ea, dea} !== 3'b110) begin
            n_bad++; $display("FAIL err_half: valid%b err%b en%b want 1 1 0", rva, ea, dea);
        end
        @(negedge clk);
    endtask

    task automatic test_latency4();
        rrb = 1'b0;
        issue(1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({deb, dwb, rb, dab, dmb} !== {1'b1, k == 3, 1'b0, 32'h0000_0010, 4'b1111}) begin
                n_bad++; $display("FAIL lat4_access%0d: en%b wen%b rdy%b addr=%h mask=%b", k, deb, dwb, rb, dab, dmb);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({rvb, eb, rdb, rb, deb} !== {2'b10, 32'd0, 2'b00}) begin
                n_bad++; $display("FAIL lat4_hold%0d: valid%b err%b rdata=%h rdy%b en%b", k, rvb, eb, rdb, rb, deb);
            end
            @(negedge clk);
        end
        rrb = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rvb, rb} !== 2'b01) begin
            n_bad++; $display("FAIL lat4_release: valid%b rdy%b want 0 1", rvb, rb);
        end
        rrb = 1'b0;
        drb = 32'hCAFE_F00D;
        issue(1'b1, 1'b0, 32'h0000_0020, 32'd0, 2'b10, 1'b0);
        repeat (4) @(negedge clk);
        drb = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({rvb, rdb} !== {1'b1, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL lat4_load_hold: valid%b rdata=%h want 1 cafef00d", rvb, rdb);
        end
        rrb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 2'b10, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({deb, dwb, rvb, rb} !== 4'b0001) begin
            n_bad++; $display("FAIL mid_reset_now: en%b wen%b valid%b rdy%b want 0 0 0 1", deb, dwb, rvb, rb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({deb, dwb, rvb, rb} !== 4'b0001) begin
                n_bad++; $display("FAIL mid_reset_after%0d: en%b wen%b valid%b rdy%b want 0 0 0 1", k, deb, dwb, rvb, rb);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        va = 1'b0; vb = 1'b0; rra = 1'b1; rrb = 1'b1;
        req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        dra = '0; drb = '0;
        @(negedge clk);
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_errors();
        test_latency4();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
